// File: rtl/trace_pkg.sv
// Trace record layout and shared constants for trace_capture_unit.
package trace_pkg;

  localparam int unsigned TRACE_REC_WIDTH = 64;
  localparam int unsigned SEQ_WIDTH       = 9;

  typedef enum logic {
    TRACE_REG = 1'b0,
    TRACE_MEM = 1'b1
  } trace_type_e;

  typedef struct packed {
    trace_type_e          rtype;
    logic [3:0]           thread;
    logic [3:0]           be;
    logic [13:0]          addr;
    logic [SEQ_WIDTH-1:0] seq;
    logic [31:0]          data;
  } trace_rec_t;

  function automatic trace_rec_t pack_rec(
    input trace_type_e          rtype,
    input logic [3:0]           thread,
    input logic [3:0]           be,
    input logic [13:0]          addr,
    input logic [SEQ_WIDTH-1:0] seq,
    input logic [31:0]          data
  );
    trace_rec_t r;
    r.rtype  = rtype;
    r.thread = thread;
    r.be     = be;
    r.addr   = addr;
    r.seq    = seq;
    r.data   = data;
    return r;
  endfunction

endpackage

// File: rtl/trace_capture_unit_if.sv
// Trace record stream (valid/ready) from the capture unit to its consumer.
interface trace_capture_unit_if;

  logic                                  o_trace_valid;
  logic                                  i_trace_ready;
  logic [trace_pkg::TRACE_REC_WIDTH-1:0] o_trace_data;

  modport master (
    output o_trace_valid,
    output o_trace_data,
    input  i_trace_ready
  );

  modport slave (
    input  o_trace_valid,
    input  o_trace_data,
    output i_trace_ready
  );

endinterface

// File: rtl/trace_fifo_2w1r.sv
// Record FIFO: two ordered write ports per cycle and a registered head (read) port.
module trace_fifo_2w1r #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_we0,
  input  logic [WIDTH-1:0]         i_wd0,
  input  logic                     i_we1,
  input  logic [WIDTH-1:0]         i_wd1,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic [AW:0]      w_wr_ptr1;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_empty_nxt;
  logic             w_pop;
  logic [AW-1:0]    w_head_idx;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_pop       = i_pop & r_valid;
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_free      = (w_full ? '0 : ((AW+1)'(DEPTH) - w_count)) + (AW+1)'(w_pop);

  assign w_wr_ptr1   = r_wr_ptr + (AW+1)'(1);
  assign w_wr_nxt    = r_wr_ptr + (AW+1)'(i_we0) + (AW+1)'(i_we0 & i_we1);
  assign w_rd_nxt    = r_rd_ptr + (AW+1)'(w_pop);
  assign w_empty_nxt = (w_wr_nxt == w_rd_nxt);
  assign w_head_idx  = w_rd_nxt[AW-1:0];

  // The head register must see a record written this same edge, so bypass the array.
  always_comb begin
    w_head_nxt = r_mem[w_head_idx];
    if (i_we0 && (r_wr_ptr[AW-1:0] == w_head_idx)) begin
      w_head_nxt = i_wd0;
    end else if (i_we0 && i_we1 && (w_wr_ptr1[AW-1:0] == w_head_idx)) begin
      w_head_nxt = i_wd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we0) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wd0;
    end
    if (i_we0 && i_we1) begin
      r_mem[w_wr_ptr1[AW-1:0]] <= i_wd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_valid  <= !w_empty_nxt;
      r_data   <= w_empty_nxt ? '0 : w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/trace_capture_unit.sv
// Converts register/memory commit events into sequenced 64-bit trace records.
// Optional thread filter: define TRACE_THREAD_FILTER_EN to add i_thread_mask.
module trace_capture_unit
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_capture_en,
  input  logic                      i_regfile_wr_en,
  input  logic [4:0]                i_regfile_wr_addr,
  input  logic [31:0]               i_regfile_wr_data,
  input  logic [3:0]                i_thread_index_wb,
  input  logic [3:0]                i_dmem_write_enable,
  input  logic [13:0]               i_dmem_addr,
  input  logic [31:0]               i_dmem_write_data,
  input  logic [3:0]                i_thread_index_wrmem,
`ifdef TRACE_THREAD_FILTER_EN
  input  logic [15:0]               i_thread_mask,
`endif
  trace_capture_unit_if.master      trace,
  output logic                      o_overflow,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [SEQ_WIDTH-1:0]        r_seq;
  logic [DROP_CNT_WIDTH-1:0]   r_drop_count;
  logic                        r_overflow;

  logic                        w_mask_wb;
  logic                        w_mask_mem;
  logic                        w_reg_evt;
  logic                        w_mem_evt;
  logic [1:0]                  w_n_evt;
  logic [1:0]                  w_n_drop;
  trace_rec_t                  w_reg_rec;
  trace_rec_t                  w_mem_rec;
  logic                        w_we0;
  logic                        w_we1;
  logic [TRACE_REC_WIDTH-1:0]  w_wd0;
  logic [TRACE_REC_WIDTH-1:0]  w_wd1;
  logic                        w_valid;
  logic [TRACE_REC_WIDTH-1:0]  w_data;
  logic                        w_pop;
  logic [AW:0]                 w_free;
  logic [DROP_CNT_WIDTH:0]     w_drop_sum;

`ifdef TRACE_THREAD_FILTER_EN
  assign w_mask_wb  = i_thread_mask[i_thread_index_wb];
  assign w_mask_mem = i_thread_mask[i_thread_index_wrmem];
`else
  assign w_mask_wb  = 1'b1;
  assign w_mask_mem = 1'b1;
`endif

  assign w_reg_evt = i_capture_en & i_regfile_wr_en & w_mask_wb;
  assign w_mem_evt = i_capture_en & (|i_dmem_write_enable) & w_mask_mem;
  assign w_n_evt   = {1'b0, w_reg_evt} + {1'b0, w_mem_evt};

  assign w_reg_rec = pack_rec(TRACE_REG, i_thread_index_wb, 4'hF,
                              {9'd0, i_regfile_wr_addr}, r_seq, i_regfile_wr_data);
  assign w_mem_rec = pack_rec(TRACE_MEM, i_thread_index_wrmem, i_dmem_write_enable,
                              i_dmem_addr, r_seq + SEQ_WIDTH'(w_reg_evt), i_dmem_write_data);

  assign w_pop = w_valid & trace.i_trace_ready;

  // Port 0 always carries the oldest event so a single free slot keeps the reg record.
  always_comb begin
    w_we0    = 1'b0;
    w_we1    = 1'b0;
    w_wd0    = w_reg_rec;
    w_wd1    = w_mem_rec;
    w_n_drop = 2'd0;
    if (w_reg_evt && w_mem_evt) begin
      if (w_free >= (AW+1)'(2)) begin
        w_we0 = 1'b1;
        w_we1 = 1'b1;
      end else if (w_free == (AW+1)'(1)) begin
        w_we0    = 1'b1;
        w_n_drop = 2'd1;
      end else begin
        w_n_drop = 2'd2;
      end
    end else if (w_reg_evt || w_mem_evt) begin
      w_wd0 = w_reg_evt ? w_reg_rec : w_mem_rec;
      if (w_free != '0) begin
        w_we0 = 1'b1;
      end else begin
        w_n_drop = 2'd1;
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop_count} + (DROP_CNT_WIDTH+1)'(w_n_drop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seq        <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_seq <= r_seq + SEQ_WIDTH'(w_n_evt);
      if (w_n_drop != 2'd0) begin
        r_overflow   <= 1'b1;
        r_drop_count <= w_drop_sum[DROP_CNT_WIDTH] ? '1 : w_drop_sum[DROP_CNT_WIDTH-1:0];
      end
    end
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_REC_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we0   (w_we0),
    .i_wd0   (w_wd0),
    .i_we1   (w_we1),
    .i_wd1   (w_wd1),
    .i_pop   (w_pop),
    .o_valid (w_valid),
    .o_data  (w_data),
    .o_free  (w_free)
  );

  assign trace.o_trace_valid = w_valid;
  assign trace.o_trace_data  = w_data;
  assign o_overflow          = r_overflow;
  assign o_drop_count        = r_drop_count;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Self-checking bench for trace_capture_unit: vector table, corner sequences, random vs queue model.
module tb_trace_capture_unit;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_capture_en;
  logic        i_regfile_wr_en;
  logic [4:0]  i_regfile_wr_addr;
  logic [31:0] i_regfile_wr_data;
  logic [3:0]  i_thread_index_wb;
  logic [3:0]  i_dmem_write_enable;
  logic [13:0] i_dmem_addr;
  logic [31:0] i_dmem_write_data;
  logic [3:0]  i_thread_index_wrmem;
  logic        o_overflow;
  logic [15:0] o_drop_count;

  trace_capture_unit_if tif();

  trace_capture_unit #(
    .DEPTH          (DEPTH),
    .DROP_CNT_WIDTH (16)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .i_capture_en         (i_capture_en),
    .i_regfile_wr_en      (i_regfile_wr_en),
    .i_regfile_wr_addr    (i_regfile_wr_addr),
    .i_regfile_wr_data    (i_regfile_wr_data),
    .i_thread_index_wb    (i_thread_index_wb),
    .i_dmem_write_enable  (i_dmem_write_enable),
    .i_dmem_addr          (i_dmem_addr),
    .i_dmem_write_data    (i_dmem_write_data),
    .i_thread_index_wrmem (i_thread_index_wrmem),
    .trace                (tif),
    .o_overflow           (o_overflow),
    .o_drop_count         (o_drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of records in FIFO order, head at index 0.
  logic [63:0] mq[$];
  int          m_seq;
  int          m_drop;
  bit          m_ovf;

  typedef struct {
    bit          en;
    bit          reg_en;
    logic [3:0]  thr_wb;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [3:0]  thr_m;
    logic [13:0] maddr;
    logic [31:0] mdata;
    bit          exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    i_regfile_wr_en      = 1'b0;
    i_regfile_wr_addr    = '0;
    i_regfile_wr_data    = '0;
    i_thread_index_wb    = '0;
    i_dmem_write_enable  = '0;
    i_dmem_addr          = '0;
    i_dmem_write_data    = '0;
    i_thread_index_wrmem = '0;
  endtask

  task automatic drive_reg(input logic [3:0] thr, input logic [4:0] addr, input logic [31:0] data);
    i_regfile_wr_en   = 1'b1;
    i_thread_index_wb = thr;
    i_regfile_wr_addr = addr;
    i_regfile_wr_data = data;
  endtask

  task automatic drive_mem(input logic [3:0] thr, input logic [13:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
    i_dmem_write_enable  = be;
    i_thread_index_wrmem = thr;
    i_dmem_addr          = addr;
    i_dmem_write_data    = data;
  endtask

  task automatic model_step();
    logic [63:0] ev[$];
    int  free;
    bit  pop;
    ev   = {};
    pop  = (mq.size() > 0) && (tif.i_trace_ready === 1'b1);
    free = DEPTH - mq.size() + (pop ? 1 : 0);
    if (pop) void'(mq.pop_front());
    if (i_capture_en && i_regfile_wr_en) begin
      ev.push_back({1'b0, i_thread_index_wb, 4'hF, 9'd0, i_regfile_wr_addr,
                    9'(m_seq), i_regfile_wr_data});
      m_seq = (m_seq + 1) % 512;
    end
    if (i_capture_en && (i_dmem_write_enable != 4'd0)) begin
      ev.push_back({1'b1, i_thread_index_wrmem, i_dmem_write_enable, i_dmem_addr,
                    9'(m_seq), i_dmem_write_data});
      m_seq = (m_seq + 1) % 512;
    end
    foreach (ev[k]) begin
      if (k < free) mq.push_back(ev[k]);
      else begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("model_valid", {63'd0, tif.o_trace_valid}, {63'd0, mq.size() > 0});
    if (mq.size() > 0) chk("model_data", tif.o_trace_data, mq[0]);
    chk("model_drop", {48'd0, o_drop_count}, 64'(m_drop));
    chk("model_ovf", {63'd0, o_overflow}, {63'd0, m_ovf});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_idle();
    i_capture_en      = 1'b1;
    tif.i_trace_ready = 1'b1;
    mq.delete();
    m_seq  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
    #1;
    chk("rst_valid", {63'd0, tif.o_trace_valid}, 64'd0);
    chk("rst_data", tif.o_trace_data, 64'd0);
    chk("rst_drop", {48'd0, o_drop_count}, 64'd0);
    chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [63:0] rec;
    logic [8:0]  sq;
    int          thresh;

    tbl[0] = '{1, 1, 4'd3,  5'd5,  32'd42,        4'h0,    4'd0, 14'h0,    32'h0,    1,
               {1'b0, 4'd3, 4'hF, 14'd5, 9'd0, 32'd42}};
    tbl[1] = '{1, 0, 4'd0,  5'd0,  32'd0,         4'h0,    4'd0, 14'h0,    32'h0,    0, 64'd0};
    tbl[2] = '{1, 0, 4'd0,  5'd0,  32'd0,         4'b0011, 4'd2, 14'h123,  32'hAABB, 1,
               {1'b1, 4'd2, 4'b0011, 14'h123, 9'd1, 32'hAABB}};
    tbl[3] = '{0, 1, 4'd9,  5'd9,  32'd99,        4'hF,    4'd9, 14'h9,    32'h9,    0, 64'd0};
    tbl[4] = '{1, 1, 4'd15, 5'd31, 32'hFFFFFFFF,  4'h0,    4'd0, 14'h0,    32'h0,    1,
               {1'b0, 4'hF, 4'hF, 14'd31, 9'd2, 32'hFFFFFFFF}};
    tbl[5] = '{1, 0, 4'd0,  5'd0,  32'd0,         4'b1000, 4'd0, 14'h3FFF, 32'd1,    1,
               {1'b1, 4'd0, 4'b1000, 14'h3FFF, 9'd3, 32'd1}};
    tbl[6] = '{1, 0, 4'd0,  5'd0,  32'd0,         4'h0,    4'd0, 14'h0,    32'h0,    0, 64'd0};

    // Vector table: one cycle per row, ready held high.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_idle();
      i_capture_en = tbl[i].en;
      if (tbl[i].reg_en) drive_reg(tbl[i].thr_wb, tbl[i].raddr, tbl[i].rdata);
      drive_mem(tbl[i].thr_m, tbl[i].maddr, tbl[i].be, tbl[i].mdata);
      cycle();
      chk($sformatf("tbl%0d_valid", i), {63'd0, tif.o_trace_valid}, {63'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), tif.o_trace_data, tbl[i].exp_data);
    end

    // Dual event in one cycle: reg first, mem second.
    do_reset();
    drive_reg(4'd1, 5'd7, 32'h11);
    drive_mem(4'd2, 14'h123, 4'b0011, 32'hAABB);
    cycle();
    chk("dual_reg", tif.o_trace_data, {1'b0, 4'd1, 4'hF, 14'd7, 9'd0, 32'h11});
    set_idle();
    cycle();
    chk("dual_mem", tif.o_trace_data, {1'b1, 4'd2, 4'b0011, 14'h123, 9'd1, 32'hAABB});
    cycle();
    chk("dual_empty", {63'd0, tif.o_trace_valid}, 64'd0);

    // Back-pressure: fill, drop a dual event, drain in order.
    do_reset();
    tif.i_trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_idle();
      drive_reg(4'(i), 5'(i), 32'(i * 3));
      cycle();
    end
    set_idle();
    drive_reg(4'd1, 5'd1, 32'h1);
    drive_mem(4'd1, 14'd1, 4'hF, 32'h2);
    cycle();
    chk("bp_drop", {48'd0, o_drop_count}, 64'd2);
    chk("bp_ovf", {63'd0, o_overflow}, 64'd1);
    set_idle();
    chk("bp_hold", tif.o_trace_data, {1'b0, 4'd0, 4'hF, 14'd0, 9'd0, 32'd0});
    tif.i_trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rec = tif.o_trace_data;
      sq  = rec[40:32];
      chk($sformatf("bp_seq%0d", i), {55'd0, sq}, 64'(i));
      cycle();
    end
    chk("bp_empty", {63'd0, tif.o_trace_valid}, 64'd0);
    drive_reg(4'd2, 5'd3, 32'h55);
    cycle();
    rec = tif.o_trace_data;
    sq  = rec[40:32];
    chk("bp_next_seq", {55'd0, sq}, 64'd18);
    set_idle();
    cycle();

    // Full FIFO, pop and dual push in the same cycle.
    do_reset();
    tif.i_trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_idle();
      drive_reg(4'd5, 5'(i), 32'(i));
      cycle();
    end
    set_idle();
    tif.i_trace_ready = 1'b1;
    drive_reg(4'd6, 5'd20, 32'hCAFE);
    drive_mem(4'd7, 14'h77, 4'b0101, 32'hBEEF);
    cycle();
    chk("fpd_drop", {48'd0, o_drop_count}, 64'd1);
    set_idle();
    for (int i = 0; i < 20; i++) cycle();

    // Sequence wrap with capture disabled for 10 cycles.
    do_reset();
    for (int i = 0; i < 530; i++) begin
      set_idle();
      i_capture_en = !(i >= 200 && i < 210);
      drive_reg(4'(i), 5'(i), 32'(i));
      cycle();
    end
    rec = tif.o_trace_data;
    sq  = rec[40:32];
    chk("wrap_last_seq", {55'd0, sq}, 64'd7);
    set_idle();
    i_capture_en = 1'b1;
    cycle();

    // Asynchronous reset with records buffered.
    do_reset();
    tif.i_trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      drive_reg(4'd3, 5'(i), 32'(100 + i));
      cycle();
    end
    set_idle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, tif.o_trace_valid}, 64'd0);
    chk("arst_data", tif.o_trace_data, 64'd0);
    do_reset();
    cycle();
    cycle();
    chk("arst_after_valid", {63'd0, tif.o_trace_valid}, 64'd0);
    chk("arst_after_drop", {48'd0, o_drop_count}, 64'd0);

    // Randomized traffic with alternating back-pressure phases.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      thresh = ((i / 60) % 2 == 0) ? 90 : 15;
      set_idle();
      i_capture_en      = ($urandom_range(0, 9) != 0);
      tif.i_trace_ready = ($urandom_range(0, 99) < thresh);
      if ($urandom_range(0, 1) != 0) drive_reg(4'($urandom), 5'($urandom), $urandom);
      if ($urandom_range(0, 1) != 0) drive_mem(4'($urandom), 14'($urandom), 4'($urandom), $urandom);
      cycle();
    end
    set_idle();
    tif.i_trace_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_capture_unit.md
Name: trace_capture_unit

Overview:
- Downstream consumer of the core's commit-debug outputs: register-file write port plus thread index at WB, and data-memory write port plus thread index at MEM.
- Converts each register write and memory write into a 64-bit trace record and buffers records in a FIFO that accepts two writes and one read per cycle.
- Drains records over a valid/ready stream to a host link or simulation monitor. Replaces per-cycle file dumping with synthesizable capture.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous, active-low reset
- i_capture_en  input  1  capture enable; 0 ignores all events
- i_regfile_wr_en  input  1  register write strobe
- i_regfile_wr_addr  input  5  register index
- i_regfile_wr_data  input  32  register write data
- i_thread_index_wb  input  4  thread of the register write
- i_dmem_write_enable  input  4  byte write enables; any bit set is a memory event
- i_dmem_addr  input  14  data memory word address
- i_dmem_write_data  input  32  memory write data
- i_thread_index_wrmem  input  4  thread of the memory write
- o_trace_valid  output  1  record available
- i_trace_ready  input  1  consumer accepts record
- o_trace_data  output  64  record at FIFO head
- o_overflow  output  1  sticky flag; set on any drop
- o_drop_count  output  DROP_CNT_WIDTH  saturating count of dropped events

Behaviour:
- Reset values: o_trace_valid=0, o_trace_data=0, o_overflow=0, o_drop_count=0. FIFO is empty and the 9-bit sequence counter is 0.
- Record format:
  - [63] type: 0=reg, 1=mem
  - [62:59] thread
  - [58:55] byte enables: reg records use 4'b1111
  - [54:41] address: reg index zero-extended to 14 bits
  - [40:32] sequence number
  - [31:0] data
- Event detection, sampled at the rising edge when i_capture_en=1:
  - reg event: i_regfile_wr_en=1
  - mem event: i_dmem_write_enable!=0
  - Both may occur in the same cycle. Order is reg first, mem second; reg gets seq, mem gets seq+1.
- Sequence counter increments once per detected event, including dropped events, so gaps reveal drops. It wraps 511->0.
- Free slots are computed as DEPTH-count, plus 1 if a pop occurs in the same cycle.
  - If free >= events, all are written.
  - If free=1 with two events, the reg record is written and the mem record is dropped.
  - If free=0, all events are dropped.
- Each dropped event increments o_drop_count by 1, saturating at all-ones; two drops in one cycle add 2. Any drop sets o_overflow until reset.
- Latency: an event sampled at edge N into an empty FIFO gives o_trace_valid=1 with the record on o_trace_data in cycle N+1. This is a registered head.
- Handshake:
  - Pop occurs when o_trace_valid and i_trace_ready are both 1.
  - o_trace_data is stable while valid=1 and ready=0.
  - The next record is presented in the following cycle with no bubble while entries remain.
- Simultaneous pop and two pushes at full: free=1, so the reg record is kept and the mem record is dropped.
- FIFO read and write pointers are log2(DEPTH)+1 bits; full/empty are derived from MSB comparison. Wrap-around requires no special handling.
- i_capture_en=0 mid-stream: no new events are taken (seq does not advance), and already buffered records still drain.
- Reset asserted mid-operation: the FIFO is flushed immediately, asynchronously, and all outputs return to their reset values.

Optional Feature:
- Macro TRACE_THREAD_FILTER_EN.
- When defined, a port i_thread_mask (input, 16 bits) is added. An event whose thread bit is 0 in the mask is discarded before detection: no record, no seq increment, no drop count.
- When undefined, the port is absent and all threads are captured.

Decomposition:
- Package trace_pkg holds:
  - trace_type_e enum: TRACE_REG=0, TRACE_MEM=1
  - trace_rec_t packed struct matching the record format
  - constants TRACE_REC_WIDTH=64 and SEQ_WIDTH=9
- Sub-module trace_fifo_2w1r: parameterised storage with two write ports (ordered) and one registered read port.
- The top level holds event detection, packing, sequencing, drop logic and the filter.

Test Plan:
- Reset and single reg event:
  - Stimulus: reset, then reg write thread 3, addr 5, data 42, with ready=1.
  - Required: one cycle later valid=1, data = {0,3,4'hF,14'd5,9'd0,32'd42}, then valid=0.
- Dual event:
  - Stimulus: in one cycle, reg write (t1, x7, 0x11) plus mem write (t2, addr 0x123, be 4'b0011, 0xAABB).
  - Required: two consecutive records, reg seq 0 then mem seq 1, be 4'b0011.
- Back-pressure:
  - Stimulus: ready=0, 16 reg events, then a dual event.
  - Required: FIFO full; both dropped; drop_count=2, overflow=1. After ready=1, 16 records drain in order, seq 0..15; next accepted event has seq 18.
- Full plus pop plus dual push:
  - Stimulus: full FIFO, ready=1, dual event.
  - Required: reg record stored, mem record dropped, drop_count +1.
- Capture disable and wrap:
  - Stimulus: 520 events with ready=1, toggling i_capture_en for 10 cycles mid-run.
  - Required: seq wraps 511->0; no records and no seq advance while disabled.
- Async reset mid-drain:
  - Stimulus: assert reset_n=0 with 5 records buffered.
  - Required: valid=0 immediately; after release, FIFO empty and drop_count=0.
